// File: rtl/sad_pkg.sv
// rtl/sad_pkg.sv - shared types and helpers for the SAD accumulator
package sad_pkg;

  localparam int DIFF_W_DEF = 9;

  typedef enum logic {
    ACCUM = 1'b0,
    STALL = 1'b1
  } state_t;

  // Counter width for indices 0..blk_len-1; never below one bit.
  function automatic int cnt_width(input int blk_len);
    return (blk_len < 2) ? 1 : $clog2(blk_len);
  endfunction

  function automatic logic [31:0] saturate(input logic [31:0] val, input logic ovf, input int w);
    logic [31:0] max_val;
    max_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ovf ? max_val : val;
  endfunction

endpackage

// File: rtl/sad_blk_counter.sv
// rtl/sad_blk_counter.sv - per-block sample counter with last-beat flags
module sad_blk_counter
  import sad_pkg::*;
#(
  parameter int BLK_LEN = 16,
  parameter int CNT_W   = cnt_width(BLK_LEN)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic beat,
  output logic last,
  output logic last_next
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLK_LEN - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (beat) begin
      cnt_nxt = last ? '0 : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign last      = (cnt == LAST_IDX);
  assign last_next = (cnt_nxt == LAST_IDX);

endmodule

// File: rtl/sad_accum.sv
// rtl/sad_accum.sv - block SAD accumulator; SAD_SAT_EN selects saturating output
module sad_accum
  import sad_pkg::*;
#(
  parameter int DIFF_W  = DIFF_W_DEF,
  parameter int BLK_LEN = 16,
  parameter int SAD_W   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIFF_W-1:0] in_diff,
  output logic              sad_valid,
  input  logic              sad_ready,
  output logic [SAD_W-1:0]  sad,
  output logic              sad_ovf
);

  generate
    if (BLK_LEN < 2) begin : g_bad_blk_len
      $error("sad_accum: BLK_LEN must be >= 2");
    end
    if (SAD_W < DIFF_W) begin : g_bad_sad_w
      $error("sad_accum: SAD_W must be >= DIFF_W");
    end
  endgenerate

  state_t            state;
  state_t            state_nxt;
  logic [SAD_W:0]    acc;
  logic              ovf_acc;
  logic [SAD_W+1:0]  sum_ext;
  logic              ovf_now;
  logic              blk_ovf;
  logic [SAD_W-1:0]  sad_nxt;
  logic              sad_valid_nxt;
  logic              last;
  logic              last_next;
  logic              accept;
  logic              accept_last;
  logic              out_beat;

  // STALL tracks "last slot reached while the output register is full";
  // sad_ready can release it combinationally in the same cycle.
  assign in_ready    = !(state == STALL && !sad_ready);
  assign accept      = in_valid && in_ready && !clr;
  assign accept_last = accept && last;
  assign out_beat    = sad_valid && sad_ready;

  sad_blk_counter #(
    .BLK_LEN (BLK_LEN)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .beat      (accept),
    .last      (last),
    .last_next (last_next)
  );

  assign sum_ext = {1'b0, acc} + (SAD_W + 2)'(in_diff);
  assign ovf_now = |sum_ext[SAD_W+1:SAD_W];
  assign blk_ovf = ovf_acc | ovf_now;

`ifdef SAD_SAT_EN
  assign sad_nxt = SAD_W'(saturate(32'(sum_ext[SAD_W:0]), blk_ovf, SAD_W));
`else
  assign sad_nxt = sum_ext[SAD_W-1:0];
`endif

  always_comb begin
    sad_valid_nxt = sad_valid;
    state_nxt     = state;
    if (accept_last) begin
      sad_valid_nxt = 1'b1;
    end else if (out_beat) begin
      sad_valid_nxt = 1'b0;
    end
    state_nxt = (last_next && sad_valid_nxt) ? STALL : ACCUM;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      ovf_acc   <= 1'b0;
      sad       <= '0;
      sad_valid <= 1'b0;
      sad_ovf   <= 1'b0;
    end else begin
      sad_valid <= sad_valid_nxt;
      if (clr || accept_last) begin
        acc     <= '0;
        ovf_acc <= 1'b0;
      end else if (accept) begin
        acc     <= sum_ext[SAD_W:0];
        ovf_acc <= blk_ovf;
      end
      if (accept_last) begin
        sad     <= sad_nxt;
        sad_ovf <= blk_ovf;
      end
    end
  end

endmodule

// File: tb/tb_sad_accum.sv
// tb/tb_sad_accum.sv - directed self-checking bench for sad_accum
module tb_sad_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [8:0]  in_diff = '0;
  logic        sad_valid;
  logic        sad_ready = 1'b0;
  logic [11:0] sad;
  logic        sad_ovf;
  logic        in_ready_w10;
  logic        sad_valid_w10;
  logic [9:0]  sad_w10;
  logic        sad_ovf_w10;

  int n_checks = 0;
  int n_fail   = 0;
  int got_sad[$];
  int stall_cycles = 0;
  int beats = 0;

  always #5 clk = ~clk;

  sad_accum dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_diff   (in_diff),
    .sad_valid (sad_valid),
    .sad_ready (sad_ready),
    .sad       (sad),
    .sad_ovf   (sad_ovf)
  );

  sad_accum #(.SAD_W(10)) dut_w10 (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready_w10),
    .in_diff   (in_diff),
    .sad_valid (sad_valid_w10),
    .sad_ready (sad_ready),
    .sad       (sad_w10),
    .sad_ovf   (sad_ovf_w10)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (sad_valid && sad_ready) got_sad.push_back(int'(sad));
      if (in_valid && in_ready && !clr) beats++;
      if (!in_ready) stall_cycles++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_diff = '0; sad_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    got_sad.delete();
    stall_cycles = 0;
    beats = 0;
  endtask

  task automatic push(input int d);
    int guard;
    guard = 0;
    in_valid = 1'b1;
    in_diff  = 9'(d);
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_sad_valid", int'(sad_valid), 0);
    check("rst_sad", int'(sad), 0);
    check("rst_sad_ovf", int'(sad_ovf), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // 1: single block of 10s, one-cycle latency
    @(posedge clk); #1;
    sad_ready = 1'b1;
    for (int i = 0; i < 15; i++) push(10);
    check("t1_no_early_valid", int'(sad_valid), 0);
    push(10);
    check("t1_valid_after_last", int'(sad_valid), 1);
    check("t1_sad", int'(sad), 160);
    check("t1_ovf", int'(sad_ovf), 0);
    settle(2);
    check("t1_drained", int'(sad_valid), 0);

    // 2: three back-to-back blocks of 255
    got_sad.delete(); stall_cycles = 0;
    for (int i = 0; i < 48; i++) push(255);
    settle(3);
    check("t2_count", got_sad.size(), 3);
    for (int i = 0; i < 3; i++) check("t2_sad", (i < got_sad.size()) ? got_sad[i] : -1, 4080);
    check("t2_no_stall", stall_cycles, 0);

    // 3: backpressure across block boundary
    do_reset();
    for (int i = 0; i < 16; i++) push(255);
    for (int i = 0; i < 15; i++) push(3);
    check("t3_no_stall_early", stall_cycles, 0);
    in_valid = 1'b1; in_diff = 9'd3;
    repeat (3) begin
      @(negedge clk);
      check("t3_in_ready_low", int'(in_ready), 0);
    end
    @(posedge clk); #1 sad_ready = 1'b1;
    @(negedge clk);
    check("t3_in_ready_release", int'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;
    settle(3);
    check("t3_count", got_sad.size(), 2);
    check("t3_first", (got_sad.size() > 0) ? got_sad[0] : -1, 4080);
    check("t3_second", (got_sad.size() > 1) ? got_sad[1] : -1, 48);
    check("t3_stall_cycles", stall_cycles, 3);
    check("t3_beats", beats, 32);

    // 4: overflow on the 10-bit instance
    do_reset();
    sad_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(100);
    check("t4_w10_valid", int'(sad_valid_w10), 1);
    check("t4_w10_ovf", int'(sad_ovf_w10), 1);
`ifdef SAD_SAT_EN
    check("t4_w10_sad", int'(sad_w10), 1023);
`else
    check("t4_w10_sad", int'(sad_w10), 576);
`endif
    check("t4_w12_sad", int'(sad), 1600);
    check("t4_w12_ovf", int'(sad_ovf), 0);
    settle(2);

    // 5: clr drops partial block and its own beat
    do_reset();
    sad_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(7);
    clr = 1'b1; in_valid = 1'b1; in_diff = 9'd7;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 16; i++) push(1);
    settle(3);
    check("t5_count", got_sad.size(), 1);
    check("t5_sad", (got_sad.size() > 0) ? got_sad[0] : -1, 16);

    // 6: reset while stalled
    do_reset();
    for (int i = 0; i < 31; i++) push(5);
    in_valid = 1'b1; in_diff = 9'd5;
    @(negedge clk);
    check("t6_stalled", int'(in_ready), 0);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_valid", int'(sad_valid), 0);
    check("t6_rst_sad", int'(sad), 0);
    check("t6_rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    got_sad.delete();
    sad_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(2);
    settle(3);
    check("t6_count", got_sad.size(), 1);
    check("t6_sad", (got_sad.size() > 0) ? got_sad[0] : -1, 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
